// File: rtl/rand_digit_pkg.sv
// Shared types and constants for the random digit generator.
// Holds the draw FSM states and the LFSR helpers.
package rand_digit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAW1,
        DRAW2,
        DONE
    } state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [3:0]  DIGIT_MAX = 4'd9;

    // One Galois step: shift right, fold the mask in when a 1 drops out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_MASK;
        end
        return nxt;
    endfunction

    // The all-zero state is a lock-up point, so never load it.
    function automatic logic [15:0] seed_fix(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and
// a one-cycle pulse when the debounced level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CNT = 250000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN_IN,
    output logic LEVEL,
    output logic RISE
);

    localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= BTN_IN;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after it has differed for the full window.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LEVEL <= 1'b0;
            RISE  <= 1'b0;
            cnt   <= '0;
        end else begin
            RISE <= 1'b0;
            if (sync_b == LEVEL) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                LEVEL <= sync_b;
                RISE  <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rand_digit_gen.sv
// Draws two BCD digits from a free-running LFSR on each button press.
// Build option RAND_NO_REPEAT_EN: second digit must differ from the first.
module rand_digit_gen
    import rand_digit_pkg::*;
#(
    parameter int          DEBOUNCE_CNT = 250000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_ROLL,
    output logic [3:0] RAND1,
    output logic [3:0] RAND2,
    output logic       VALID,
    output logic       BUSY
);

    localparam logic [15:0] SEED = seed_fix(LFSR_SEED);

    logic        btn_level;
    logic        btn_rise;
    logic        roll_req;
    logic [15:0] lfsr;
    state_t      state;
    state_t      state_nx;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  cand1;
    logic [3:0]  cand2;
    logic        d1_ok;
    logic        d2_ok;
    logic        ld_d1;
    logic        ld_d2;
    logic        ld_out;

    btn_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
        .CLK   (CLK),
        .RESET (RESET),
        .BTN_IN(BTN_ROLL),
        .LEVEL (btn_level),
        .RISE  (btn_rise)
    );

    // RISE and LEVEL are set on the same edge; both high marks a press.
    assign roll_req = btn_rise & btn_level;

    // Free-running LFSR, stepping every cycle so draw timing adds entropy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign cand1 = lfsr[3:0];
    assign cand2 = lfsr[11:8];
    assign d1_ok = (cand1 <= DIGIT_MAX);

`ifdef RAND_NO_REPEAT_EN
    assign d2_ok = (cand2 <= DIGIT_MAX) && (cand2 != d1);
`else
    assign d2_ok = (cand2 <= DIGIT_MAX);
`endif

    // Draw state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and load strobes; rejected candidates retry next cycle.
    always_comb begin
        state_nx = state;
        ld_d1    = 1'b0;
        ld_d2    = 1'b0;
        ld_out   = 1'b0;
        unique case (state)
            IDLE: begin
                if (roll_req) begin
                    state_nx = DRAW1;
                end
            end
            DRAW1: begin
                if (d1_ok) begin
                    ld_d1    = 1'b1;
                    state_nx = DRAW2;
                end
            end
            DRAW2: begin
                if (d2_ok) begin
                    ld_d2    = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                ld_out   = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // Scratch digits held until the pair is complete.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            d1 <= 4'd0;
            d2 <= 4'd0;
        end else begin
            if (ld_d1) begin
                d1 <= cand1;
            end
            if (ld_d2) begin
                d2 <= cand2;
            end
        end
    end

    // Both digits update on one edge so the display never sees a mix.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RAND1 <= 4'd0;
            RAND2 <= 4'd0;
            VALID <= 1'b0;
        end else begin
            VALID <= ld_out;
            if (ld_out) begin
                RAND1 <= d1;
                RAND2 <= d2;
            end
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_rand_digit_gen.sv
// Randomized bench for rand_digit_gen with a cycle-indexed LFSR model.
// Expected draws come from scanning the model sequence by the draw rules.
module tb_rand_digit_gen;

    localparam int N      = 4;
    localparam int PERIOD = 65535;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BTN_ROLL = 1'b0;
    logic [3:0] RAND1;
    logic [3:0] RAND2;
    logic       VALID;
    logic       BUSY;

    rand_digit_gen #(
        .DEBOUNCE_CNT(N),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .BTN_ROLL(BTN_ROLL),
        .RAND1   (RAND1),
        .RAND2   (RAND2),
        .VALID   (VALID),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc;
    logic [15:0] seq [PERIOD];

    int valid_cnt = 0;
    int vcyc = -1;
    int vr1 = 0;
    int vr2 = 0;
    int range_err = 0;
    int busy_err = 0;
    int busy_lo = -1;
    int busy_hi = -2;
    int hist1 [10];
    int hist2 [10];

    // Edges since reset release: the LFSR holds seq[cyc] in that cycle.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lf(input int k);
        return seq[k % PERIOD];
    endfunction

    function automatic bit ok2(input logic [3:0] c, input int first);
`ifdef RAND_NO_REPEAT_EN
        return (c <= 4'd9) && (int'(c) != first);
`else
        return (c <= 4'd9) && (first >= 0);
`endif
    endfunction

    // Scan the sequence from the first DRAW1 cycle for acceptable digits.
    task automatic predict(input int j1, output int a, output int b,
                           output int d1, output int d2);
        logic [15:0] v;
        a = j1;
        v = lf(a);
        while (v[3:0] > 4'd9) begin
            a++;
            v = lf(a);
        end
        d1 = int'(v[3:0]);
        b = a + 1;
        v = lf(b);
        while (!ok2(v[11:8], d1)) begin
            b++;
            v = lf(b);
        end
        d2 = int'(v[11:8]);
    endtask

    // Press first sampled at edge e0: debounced rise at e0+1+N,
    // first draw cycle at e0+N+2, pair visible with VALID at b+2.
    task automatic expect_roll(input int e0, output int a, output int b,
                               output int d1, output int d2);
        predict(e0 + N + 2, a, b, d1, d2);
        busy_lo = e0 + N + 2;
        busy_hi = b + 1;
    endtask

    task automatic step();
        @(negedge CLK);
        if (VALID === 1'b1) begin
            valid_cnt++;
            vcyc = cyc;
            vr1 = int'(RAND1);
            vr2 = int'(RAND2);
            if (RAND1 > 4'd9 || RAND2 > 4'd9) range_err++;
        end
        if (BUSY !== ((cyc >= busy_lo) && (cyc <= busy_hi))) busy_err++;
    endtask

    task automatic wait_valid(input string tag, input int v0, input int vexp,
                              input int d1, input int d2);
        int n = 0;
        while (valid_cnt == v0 && n < 200) begin
            step();
            n++;
        end
        check({tag, "_seen"}, valid_cnt - v0, 1);
        check({tag, "_cyc"}, vcyc, vexp);
        check({tag, "_r1"}, vr1, d1);
        check({tag, "_r2"}, vr2, d2);
    endtask

    initial begin
        int e0, a, b, d1, d2, v0, hold, r1, r2;
        bit found;
        seq[0] = 16'hACE1;
        for (int k = 1; k < PERIOD; k++) begin
            seq[k] = (seq[k-1] >> 1) ^ (seq[k-1][0] ? 16'hB400 : 16'h0000);
        end
        for (int d = 0; d < 10; d++) begin
            hist1[d] = 0;
            hist2[d] = 0;
        end

        repeat (3) step();
        check("rst_rand1", int'(RAND1), 0);
        check("rst_rand2", int'(RAND2), 0);
        check("rst_valid", int'(VALID), 0);
        check("rst_busy", int'(BUSY), 0);
        RESET = 1'b0;
        repeat (5) step();

        // 1: clean 12-cycle press
        v0 = valid_cnt;
        e0 = cyc + 1;
        BTN_ROLL = 1'b1;
        expect_roll(e0, a, b, d1, d2);
        repeat (12) step();
        BTN_ROLL = 1'b0;
        repeat (52) step();
        check("t1_count", valid_cnt - v0, 1);
        check("t1_cyc", vcyc, b + 2);
        check("t1_r1", vr1, d1);
        check("t1_r2", vr2, d2);
        check("t1_busy", busy_err, 0);
        repeat (N + 4) step();

        // 2: bounce, then steady press
        v0 = valid_cnt;
        e0 = 0;
        for (int i = 0; i < 30; i++) begin
            BTN_ROLL = ((i / 2) % 2 == 0);
            if (i == 28) e0 = cyc + 1;
            step();
        end
        check("t2_quiet", valid_cnt - v0, 0);
        expect_roll(e0, a, b, d1, d2);
        repeat (N) step();
        BTN_ROLL = 1'b0;
        wait_valid("t2", v0, b + 2, d1, d2);
        repeat (2 * N + 4) step();
        check("t2_once", valid_cnt - v0, 1);

        // 3: second press whose debounced edge lands mid-draw
        found = 1'b0;
        e0 = cyc + 2;
        for (int k = 0; k < 60000 && !found; k++) begin
            predict(e0 + N + 2, a, b, d1, d2);
            if (b + 1 >= e0 + 3 * N + 1) found = 1'b1;
            else e0++;
        end
        check("t3_found", int'(found), 1);
        if (found) begin
            while (cyc < e0 - 1) step();
            v0 = valid_cnt;
            BTN_ROLL = 1'b1;
            expect_roll(e0, a, b, d1, d2);
            repeat (N) step();
            BTN_ROLL = 1'b0;
            while (cyc < e0 + 2 * N - 1) step();
            BTN_ROLL = 1'b1;
            repeat (N + 2) step();
            BTN_ROLL = 1'b0;
            check("t3_busy_at_req", int'(BUSY), 1);
            wait_valid("t3", v0, b + 2, d1, d2);
            repeat (40) step();
            check("t3_once", valid_cnt - v0, 1);
            check("t3_hold_r1", int'(RAND1), d1);
            check("t3_hold_r2", int'(RAND2), d2);
        end

        // 4: reset while in DRAW2
        v0 = valid_cnt;
        e0 = cyc + 1;
        BTN_ROLL = 1'b1;
        expect_roll(e0, a, b, d1, d2);
        repeat (N) step();
        BTN_ROLL = 1'b0;
        while (cyc < a + 1) step();
        check("t4_busy_pre", int'(BUSY), 1);
        RESET = 1'b1;
        #1;
        check("t4_rand1", int'(RAND1), 0);
        check("t4_rand2", int'(RAND2), 0);
        check("t4_busy", int'(BUSY), 0);
        check("t4_valid", int'(VALID), 0);
        busy_lo = -1;
        busy_hi = -2;
        step();
        step();
        RESET = 1'b0;
        repeat (40) step();
        check("t4_no_valid", valid_cnt - v0, 0);

        // 5: many rolls at random times
        for (int r = 0; r < 1000; r++) begin
            repeat ($urandom_range(0, 4)) step();
            hold = N + int'($urandom_range(0, 3));
            v0 = valid_cnt;
            e0 = cyc + 1;
            BTN_ROLL = 1'b1;
            expect_roll(e0, a, b, d1, d2);
            repeat (hold) step();
            BTN_ROLL = 1'b0;
            wait_valid("t5", v0, b + 2, d1, d2);
            if (vr1 < 10) hist1[vr1]++;
            if (vr2 < 10) hist2[vr2]++;
`ifdef RAND_NO_REPEAT_EN
            check("t5_distinct", int'(vr1 != vr2), 1);
`endif
            while (cyc < e0 + hold + N + 3) step();
        end
        for (int d = 0; d < 10; d++) begin
            check($sformatf("t5_hist1_%0d", d), int'(hist1[d] >= 50), 1);
            check($sformatf("t5_hist2_%0d", d), int'(hist2[d] >= 50), 1);
        end

        // 6: long idle keeps outputs
        r1 = int'(RAND1);
        r2 = int'(RAND2);
        v0 = valid_cnt;
        repeat (10000) step();
        check("t6_r1", int'(RAND1), r1);
        check("t6_r2", int'(RAND2), r2);
        check("t6_valid", valid_cnt - v0, 0);

        check("busy_window", busy_err, 0);
        check("digit_range", range_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
